// File: rtl/gf_pkg.sv
// GF(2^M) reducer shared definitions.
// State encoding and width helpers.
package gf_pkg;

  localparam int M_DEF  = 8;
  localparam int PW_DEF = 2 * M_DEF - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ceil(log2(v)), at least 1 so every counter has a bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // width of an unreduced product
  function automatic int pw(input int m);
    return 2 * m - 1;
  endfunction

  // busy cycles per operation: ceil((m-1)/d)
  function automatic int nstep(input int m, input int d);
    return (m - 1 + d - 1) / d;
  endfunction

endpackage

// File: rtl/gf_reduce_step.sv
// One digit of reduction: D chained
// conditional shifted-POLY XORs.
module gf_reduce_step
  import gf_pkg::*;
#(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B,
  parameter int         D    = 2,
  localparam int        PW   = 2 * M - 1,
  localparam int        PBW  = clog2(PW)
) (
  input  logic [PW-1:0]  r,
  input  logic [PBW-1:0] p,
  output logic [PW-1:0]  r_nxt
);

  localparam logic [PW-1:0] PPOLY = PW'(POLY);

  // clear positions p..p-D+1 top-down;
  // positions below M are left alone
  always_comb begin
    logic [PW-1:0] t;
    int            pos;
    t   = r;
    pos = 0;
    for (int k = 0; k < D; k++) begin
      pos = int'(p) - k;
      if (pos >= M && pos < PW) begin
        if (t[pos]) t = t ^ (PPOLY << (pos - M));
      end
    end
    r_nxt = t;
  end

endmodule

// File: rtl/gf_reduce_seq.sv
// Digit-serial GF(2^M) reducer with
// valid/ready on both sides.
module gf_reduce_seq
  import gf_pkg::*;
#(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11B,
  parameter int         D    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*M-2:0] in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int PW  = pw(M);
  localparam int NS  = nstep(M, D);
  localparam int CW  = clog2(NS + 1);
  localparam int PBW = clog2(PW);
  localparam int TOP = 2 * M - 2;

  state_t         state;
  state_t         state_nxt;
  logic [PW-1:0]  r;
  logic [PW-1:0]  r_nxt;
  logic [CW-1:0]  cnt;
  logic [PBW-1:0] p;
  logic           last;
  logic           accept;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CW'(NS - 1));
  assign p      = PBW'(TOP - int'(cnt) * D);

  gf_reduce_step #(
    .M    (M),
    .POLY (POLY),
    .D    (D)
  ) u_step (
    .r     (r),
    .p     (p),
    .r_nxt (r_nxt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept)    state_nxt = S_BUSY;
      S_BUSY:  if (last)      state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs straight from state
  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    busy      = (state == S_BUSY);
    out_valid = (state == S_DONE);
  end

  // work register, step count, result
  always_ff @(posedge clk) begin
    if (rst) begin
      r        <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            r   <= in_data;
            cnt <= '0;
          end
        end
        S_BUSY: begin
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
          if (last) out_data <= r_nxt[M-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Scoreboard bench for gf_reduce_seq.
// Directed D=2 run plus D sweep.
module tb_gf_reduce_seq;
  import gf_pkg::*;

  localparam int         M    = 8;
  localparam int         PW   = 2 * M - 1;
  localparam logic [M:0] POLY = 9'h11B;
  localparam int         NSD  = 4;

  typedef struct {
    logic [M-1:0] d;
    int           c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // sum of x^i mod POLY over the set bits
  function automatic logic [M-1:0] ref_red(
    input logic [PW-1:0] v);
    logic [M:0]   a;
    logic [M-1:0] acc;
    a   = 1;
    acc = '0;
    for (int i = 0; i < PW; i++) begin
      if (v[i]) acc = acc ^ a[M-1:0];
      a = a << 1;
      if (a[M]) a = a ^ POLY;
    end
    return acc;
  endfunction

  function automatic int dsel(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 7;
    endcase
  endfunction

  // ---------------- directed instance (D=2)
  logic          rst_d = 1'b1;
  logic [PW-1:0] dd = '0;
  logic          dv = 1'b0;
  logic          dir;
  logic [M-1:0]  dod;
  logic          dov;
  logic          dor = 1'b1;
  logic          dbusy;
  logic          fin_d = 1'b0;

  gf_reduce_seq #(.M(M), .POLY(POLY), .D(2)) u_dut (
    .clk       (clk),
    .rst       (rst_d),
    .in_data   (dd),
    .in_valid  (dv),
    .in_ready  (dir),
    .out_data  (dod),
    .out_valid (dov),
    .out_ready (dor),
    .busy      (dbusy)
  );

  exp_t qd[$];
  int   rise_d = 0;
  logic pv_d = 1'b0;

  // directed monitor
  always @(negedge clk) begin
    exp_t e;
    if (dov && !pv_d) rise_d = cyc;
    pv_d = dov;
    if (!rst_d && dov && dor) begin
      if (qd.size() == 0) begin
        chk("d2 unexpected out", 32'(dod), 0);
      end else begin
        e = qd.pop_front();
        chk("d2 data", 32'(dod), 32'(e.d));
        chk("d2 latency", 32'(rise_d - e.c - 1),
            32'(NSD));
      end
    end
  end

  task automatic send_d(input logic [PW-1:0] v);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    dd = v;
    dv = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (dir) begin
        qd.push_back('{ref_red(v), cyc});
        ok = 1;
      end
    end
    if (!ok) chk("d2 accept timeout", 0, 1);
    @(posedge clk);
    #1;
    dv = 1'b0;
  endtask

  task automatic drain_d();
    for (int t = 0; t < 200 && qd.size() != 0; t++)
      @(negedge clk);
    chk("d2 drain", 32'(qd.size()), 0);
  endtask

  initial begin
    int acc[6];
    bit ok;
    logic [M-1:0] hold;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(dov), 0);
    chk("rst busy", 32'(dbusy), 0);
    chk("rst out_data", 32'(dod), 0);
    chk("rst in_ready", 32'(dir), 0);
    @(posedge clk);
    #1 rst_d = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", 32'(dir), 1);
    // constants straight from field arithmetic
    chk("ref 57*83", 32'(ref_red(15'h2B79)), 32'hC1);
    chk("ref x^8", 32'(ref_red(15'h0100)), 32'h1B);
    send_d(15'h2B79);
    send_d(15'h0100);
    send_d(15'h4000);
    send_d(15'h00FF);
    drain_d();
    // back-pressure
    dor = 1'b0;
    hold = ref_red(15'h1234);
    send_d(15'h1234);
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = dov;
    end
    if (!ok) chk("bp valid timeout", 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp hold data", 32'(dod), 32'(hold));
      chk("bp in_ready", 32'(dir), 0);
      chk("bp valid", 32'(dov), 1);
    end
    @(posedge clk);
    #1 dor = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp idle in_ready", 32'(dir), 1);
    chk("bp idle valid", 32'(dov), 0);
    // reset during the second busy cycle
    send_d(15'h7FFF);
    @(posedge clk);
    #1 rst_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort out_valid", 32'(dov), 0);
    chk("abort busy", 32'(dbusy), 0);
    chk("abort out_data", 32'(dod), 0);
    qd.delete();
    @(posedge clk);
    #1 rst_d = 1'b0;
    send_d(15'h2B79);
    drain_d();
    // in_valid held high: accept spacing is
    // NSTEP busy edges, DONE, then IDLE
    @(posedge clk);
    #1;
    dd = PW'($urandom());
    dv = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ok = 0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        if (dir) begin
          qd.push_back('{ref_red(dd), cyc});
          acc[n] = cyc;
          ok = 1;
        end
      end
      if (!ok) chk("stream timeout", 0, 1);
      @(posedge clk);
      #1 dd = PW'($urandom());
    end
    dv = 1'b0;
    for (int n = 1; n < 6; n++)
      chk("stream spacing", 32'(acc[n] - acc[n-1]),
          32'(NSD + 2));
    drain_d();
    fin_d = 1'b1;
  end

  // ---------------- D sweep
  logic rst_s = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int DG  = dsel(g);
    localparam int NSG = (M - 1 + DG - 1) / DG;

    logic [PW-1:0] idat = '0;
    logic          iv = 1'b0;
    logic          ird;
    logic [M-1:0]  od;
    logic          ov;
    logic          ordy = 1'b1;
    logic          bz;
    logic          fin = 1'b0;
    exp_t          q[$];
    int            rise = 0;
    logic          pv = 1'b0;

    gf_reduce_seq #(.M(M), .POLY(POLY), .D(DG)) u (
      .clk       (clk),
      .rst       (rst_s),
      .in_data   (idat),
      .in_valid  (iv),
      .in_ready  (ird),
      .out_data  (od),
      .out_valid (ov),
      .out_ready (ordy),
      .busy      (bz)
    );

    initial begin
      forever begin
        @(posedge clk);
        #1 ordy = ($urandom_range(0, 3) != 0);
      end
    end

    always @(negedge clk) begin
      exp_t e;
      if (ov && !pv) rise = cyc;
      pv = ov;
      if (!rst_s && ov && ordy) begin
        if (q.size() == 0) begin
          chk($sformatf("D%0d unexpected", DG),
              32'(od), 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("D%0d data", DG),
              32'(od), 32'(e.d));
          chk($sformatf("D%0d latency", DG),
              32'(rise - e.c - 1), 32'(NSG));
        end
      end
    end

    initial begin
      logic [PW-1:0] v;
      bit ok;
      wait (!rst_s);
      @(posedge clk);
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        v = PW'($urandom());
        if ($urandom_range(0, 7) == 0) v = PW'(v[M-1:0]);
        #1;
        idat = v;
        iv = 1'b1;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
          @(negedge clk);
          if (ird) begin
            q.push_back('{ref_red(v), cyc});
            ok = 1;
          end
        end
        if (!ok) chk($sformatf("D%0d accept", DG), 0, 1);
        @(posedge clk);
        #1 iv = 1'b0;
      end
      for (int t = 0; t < 200 && q.size() != 0; t++)
        @(negedge clk);
      chk($sformatf("D%0d drain", DG),
          32'(q.size()), 0);
      fin = 1'b1;
    end
  end

  initial begin
    bit all;
    repeat (3) @(posedge clk);
    #1 rst_s = 1'b0;
    all = 0;
    for (int t = 0; t < 60000 && !all; t++) begin
      @(posedge clk);
      all = fin_d && sw[0].fin && sw[1].fin &&
            sw[2].fin && sw[3].fin;
    end
    chk("run timeout", 32'(all), 1);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
